onay_ctrl: RTL
==============

ONAY_CTRL -- requirements
Module: onay_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the valid-RAM index width.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning the valid-RAM entry count; it SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 fill_req  input  1  request to set the valid bit at fill_idx; held until fill_ack.
REQ-006 fill_idx  input  ADDR_W  line index to validate.
REQ-007 fill_ack  output  1  fill write issued this cycle.
REQ-008 inv_req  input  1  request to clear the valid bit at inv_idx; held until inv_ack.
REQ-009 inv_idx  input  ADDR_W  line index to invalidate.
REQ-010 inv_ack  output  1  invalidate write issued this cycle.
REQ-011 flush_req  input  1  request to invalidate all entries.
REQ-012 flush_busy  output  1  flush sweep in progress.
REQ-013 flush_done  output  1  one-cycle pulse after the flush sweep completes.
REQ-014 lkp_idx  input  ADDR_W  lookup index.
REQ-015 lkp_valid  output  1  valid bit of lkp_idx; meaningful only when lkp_stall=0.
REQ-016 lkp_stall  output  1  lookup not serviced this cycle.
REQ-017 ready  output  1  controller in IDLE.
REQ-018 ram_w_en  output  1  valid-RAM write enable.
REQ-019 ram_addr  output  ADDR_W  valid-RAM address.
REQ-020 ram_data_in  output  1  valid-RAM write data.
REQ-021 ram_data_o  input  1  valid-RAM asynchronous read data.

Function
REQ-022 States SHALL be CLEAR, IDLE, FLUSH; cnt (ADDR_W bits) SHALL be the sweep counter.
REQ-023 CLEAR and FLUSH: ram_w_en=1, ram_addr=cnt, ram_data_in=0; cnt increments each edge; at edge with cnt==DEPTH-1, state->IDLE, cnt->0.
REQ-024 CLEAR SHALL take exactly DEPTH cycles; ready SHALL rise on cycle DEPTH after rst_n release (cycles counted from 0).
REQ-025 IDLE port priority SHALL be flush > inv > fill > lookup; at most one RAM write per cycle.
REQ-026 flush_req in IDLE: no write that cycle, lkp_stall=1, state->FLUSH with cnt=0 at next edge.
REQ-027 inv granted: ram_w_en=1, ram_addr=inv_idx, ram_data_in=0, inv_ack=1 combinationally same cycle.
REQ-028 fill granted: ram_w_en=1, ram_addr=fill_idx, ram_data_in=1, fill_ack=1 combinationally same cycle.
REQ-029 No write in IDLE: ram_w_en=0, ram_addr=lkp_idx, lkp_stall=0, lkp_valid=ram_data_o.
REQ-030 lkp_stall SHALL be 1 and lkp_valid 0 whenever ready=0 or a write is issued.
REQ-031 Acks SHALL be 0 outside IDLE; fill/inv requests during CLEAR/FLUSH wait, not dropped.
REQ-032 flush_req during CLEAR or FLUSH SHALL be ignored (no extra sweep).
REQ-033 flush_busy SHALL equal (state==FLUSH); flush_done SHALL be a registered 1-cycle pulse in the first IDLE cycle after FLUSH; not after CLEAR.
REQ-034 Simultaneous inv_req and fill_req: inv acked first, fill acked next cycle if still held (same index ends valid=1).
REQ-035 cnt wrap SHALL never pass DEPTH-1; no address beyond DEPTH-1 SHALL be driven.

Reset
REQ-036 rst_n=0 at an edge SHALL force state=CLEAR, cnt=0, flush_done=0, from any state including mid-FLUSH.
REQ-037 While rst_n=0: ram_w_en=0, fill_ack=0, inv_ack=0, ready=0, flush_busy=0, lkp_stall=1, lkp_valid=0.

Verification
REQ-038 Release rst_n, all requests low -> ram_w_en=1 addrs 0..1023 data 0 over 1024 cycles; ready=1 at cycle 1024.
REQ-039 IDLE, fill_req idx=5 one cycle -> fill_ack=1 same cycle; next cycle lkp_idx=5 -> lkp_stall=0, lkp_valid=1.
REQ-040 fill_req idx=7 and inv_req idx=7 same cycle -> inv_ack then fill_ack next cycle; lookup 7 -> lkp_valid=1.
REQ-041 Fill idx 3,900; flush_req one cycle -> flush_busy 1024 cycles, flush_done 1 pulse; lookups 3,900 -> lkp_valid=0.
REQ-042 rst_n low at FLUSH cnt=500 -> next cycle CLEAR cnt=0, flush_done never pulses; ready after 1024 more cycles.
REQ-043 fill_req held during FLUSH -> fill_ack=0 until first IDLE cycle, then fill_ack=1 there.

Source files
------------

// File: rtl/onay_ctrl.sv
// Valid-bit RAM controller: sweeps the RAM clear after reset and on flush, and
// arbitrates flush, invalidate, fill and lookup onto one RAM port in IDLE.
module onay_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_idx,
  output logic              fill_ack,
  input  logic              inv_req,
  input  logic [ADDR_W-1:0] inv_idx,
  output logic              inv_ack,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic              flush_done,
  input  logic [ADDR_W-1:0] lkp_idx,
  output logic              lkp_valid,
  output logic              lkp_stall,
  output logic              ready,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data_in,
  input  logic              ram_data_o
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              flush_done_q, flush_done_d;
  logic              sweep_last;

  assign sweep_last = (cnt_q == LAST_IDX);
  assign flush_done = flush_done_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    fill_ack     = 1'b0;
    inv_ack      = 1'b0;
    flush_busy   = 1'b0;
    lkp_valid    = 1'b0;
    lkp_stall    = 1'b1;
    ready        = 1'b0;
    ram_w_en     = 1'b0;
    ram_addr     = lkp_idx;
    ram_data_in  = 1'b0;

    case (state_q)
      ST_CLEAR, ST_FLUSH: begin
        ram_w_en   = 1'b1;
        ram_addr   = cnt_q;
        flush_busy = (state_q == ST_FLUSH);
        if (sweep_last) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          flush_done_d = (state_q == ST_FLUSH);
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else if (inv_req) begin
          ram_w_en = 1'b1;
          ram_addr = inv_idx;
          inv_ack  = 1'b1;
        end else if (fill_req) begin
          ram_w_en    = 1'b1;
          ram_addr    = fill_idx;
          ram_data_in = 1'b1;
          fill_ack    = 1'b1;
        end else begin
          lkp_stall = 1'b0;
          lkp_valid = ram_data_o;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase

    // Hold every side effect quiet while reset is asserted.
    if (!rst_n) begin
      fill_ack   = 1'b0;
      inv_ack    = 1'b0;
      flush_busy = 1'b0;
      lkp_valid  = 1'b0;
      lkp_stall  = 1'b1;
      ready      = 1'b0;
      ram_w_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule
